// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - default widths for register addresses and performance counters
//   - controller state type; each state names the cause of the action
//     that the controller took in the previous cycle
//   - helper that tells whether load-use detection is masked in a state
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int REG_AW_DEFAULT = 5;
    localparam int CNT_W_DEFAULT  = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_FLUSH   = 2'b10,
        ST_MEMWAIT = 2'b11
    } state_e;

    // After a flush ID holds a NOP, and after a load-use stall ID/EX holds a
    // bubble; in both cases the comparison against ID/EX is stale for a cycle.
    function automatic logic lu_masked(input state_e st);
        logic masked;
        case (st)
            ST_FLUSH:   masked = 1'b1;
            ST_LDSTALL: masked = 1'b1;
            default:    masked = 1'b0;
        endcase
        return masked;
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use detector. A load in EX whose destination is
// read by the instruction in ID cannot be forwarded in time.
// Ports:
//   ex_memread   : ID/EX holds a load
//   ex_rd        : destination register held in ID/EX
//   id_rs1       : first source register of the ID instruction
//   id_rs2       : second source register of the ID instruction
//   id_uses_rs2  : ID instruction actually reads rs2
//   load_use     : hazard detected (register 0 never counts)
// -----------------------------------------------------------------------------
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    output logic              load_use
);

    logic rd_nonzero_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    assign rd_nonzero_s = (ex_rd != {REG_AW{1'b0}});
    assign rs1_hit_s    = (ex_rd == id_rs1);
    assign rs2_hit_s    = id_uses_rs2 & (ex_rd == id_rs2);
    assign load_use     = ex_memread & rd_nonzero_s & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: memory freeze, taken-branch flush and load-use
// stall, with saturating stall/flush performance counters.
// Control outputs are Mealy (current state + inputs) so they act at the very
// next clock edge.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   id_rs1, id_rs2        : ID source registers
//   id_uses_rs2           : ID instruction reads rs2
//   ex_memread, ex_rd     : load flag / destination held in ID/EX
//   branch_taken          : taken branch/jump resolved in EX
//   mem_req, mem_ready    : MEM data access pending / completing
//   pc_write, ifid_write  : PC and IF/ID update enables
//   ifid_flush            : load NOP into IF/ID
//   idex_bubble           : load zero control into ID/EX
//   idex_hold, exmem_hold : hold ID/EX and EX/MEM
//   state                 : current controller state
//   stall_cnt, flush_cnt  : saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              idex_hold,
    output logic              exmem_hold,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d;

    logic              load_use_s;
    logic              freeze_s;
    logic              flush_act_s;
    logic              stall_act_s;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_detect (
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use_s)
    );

    // Priority chain: a stalled memory access freezes everything, so a branch
    // seen during the freeze is only acted on in the release cycle.
    assign freeze_s    = mem_req & ~mem_ready;
    assign flush_act_s = ~freeze_s & branch_taken;
    assign stall_act_s = ~freeze_s & ~branch_taken & load_use_s & ~lu_masked(state_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the state records why the controller acted this cycle
    always_comb begin
        state_d = ST_RUN;
        if (reset) begin
            state_d = ST_RUN;
        end else if (freeze_s) begin
            state_d = ST_MEMWAIT;
        end else if (flush_act_s) begin
            state_d = ST_FLUSH;
        end else if (stall_act_s) begin
            state_d = ST_LDSTALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Output decode
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        exmem_hold  = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (freeze_s) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_hold   = 1'b1;
            exmem_hold  = 1'b1;
        end else if (flush_act_s) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall_act_s) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
        end
    end

    // Counter next values; both saturate at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (~pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_act_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, 5, register-address width of rd/rs fields.
REQ-002 Parameter CNT_W, 16, width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 id_rs1, id_rs2  input  REG_AW each  source registers of the instruction in ID.
REQ-006 id_uses_rs2  input  1  ID instruction reads rs2 (R-type, store).
REQ-007 ex_memread, ex_rd  input  1 / REG_AW  memread and rd currently held in the ID/EX pipeline register.
REQ-008 branch_taken  input  1  taken branch or jump resolved in EX this cycle.
REQ-009 mem_req, mem_ready  input  1 each  MEM-stage data-memory access pending / completing this cycle.
REQ-010 pc_write, ifid_write  output  1 each  enable PC and IF/ID updates.
REQ-011 ifid_flush  output  1  load NOP into IF/ID.
REQ-012 idex_bubble  output  1  load all-zero control (bubble) into ID/EX.
REQ-013 idex_hold, exmem_hold  output  1 each  hold ID/EX and EX/MEM contents.
REQ-014 state  output  2  current FSM state.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-016 States: RUN=00, LDSTALL=01, FLUSH=10, MEMWAIT=11; the state records the cause of the previous cycle's action.
REQ-017 load_use = ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-018 Outputs are combinational from the current state and inputs (Mealy) and take effect at the next clock edge; zero added latency.
REQ-019 Priority 1, freeze (mem_req & !mem_ready): pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, ifid_flush=0, idex_bubble=0; next state MEMWAIT.
REQ-020 Priority 2, branch_taken (not frozen): ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, holds 0; next state FLUSH.
REQ-021 Priority 3, load_use while state is neither FLUSH nor LDSTALL: pc_write=0, ifid_write=0, idex_bubble=1, holds 0; next state LDSTALL.
REQ-022 Otherwise: pc_write=1, ifid_write=1, all other control outputs 0; next state RUN.
REQ-023 In MEMWAIT, freeze persists while mem_ready=0; the first cycle with mem_ready=1 is evaluated by REQ-020..022 in that same cycle.
REQ-024 A branch_taken held high during a freeze is acted on only in the release cycle; it is never lost and never applied twice.
REQ-025 load_use is masked for one cycle in FLUSH (ID holds a NOP) and in LDSTALL (ID/EX holds a bubble): at most one load-use stall per load.
REQ-026 stall_cnt increments by 1 in every cycle with pc_write=0 (excluding reset); saturates at all-ones.
REQ-027 flush_cnt increments by 1 per cycle acting on REQ-020; saturates at all-ones.

Reset
REQ-028 While reset=1: state=RUN, stall_cnt=0, flush_cnt=0, pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, idex_hold=0, exmem_hold=0.
REQ-029 Reset asserted in any state, including mid-MEMWAIT, returns to RUN at the next edge; no pending branch or stall survives reset.

Structure
REQ-030 Package hazard_ctrl_pkg holds the state type/encodings and the REG_AW and CNT_W defaults.
REQ-031 Sub-module hazard_detect is purely combinational and computes load_use (REQ-017); FSM, output decode and counters live in hazard_ctrl.

Verification
REQ-032 ex_memread=1, ex_rd=5, id_rs1=5 in RUN -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; then RUN outputs; stall_cnt=1.
REQ-033 ex_memread=1, ex_rd=0, id_rs1=0 -> no stall, pc_write=1; and ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall.
REQ-034 branch_taken=1 with load_use true in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, next state FLUSH, flush_cnt=1, no LDSTALL.
REQ-035 mem_req=1, mem_ready=0 for 3 cycles with branch_taken=1 -> 3 freeze cycles (idex_hold=exmem_hold=1), then in the mem_ready=1 cycle a single flush; stall_cnt=3, flush_cnt=1.
REQ-036 reset=1 pulsed during MEMWAIT -> reset outputs per REQ-028 that cycle, state=RUN and both counters 0 after the edge.
REQ-037 Force stall_cnt to all-ones, then one further stall -> stall_cnt remains all-ones.
